rs_block_ctrl: RTL
==================

Name: rs_block_ctrl

Overview:
- Block sequencer in front of the RS(255,239,T=8) byte encoder in the WiMAX OFDM transmit chain.
- Pulls exactly K data bytes per block from an upstream FIFO and feeds them to the encoder back-to-back with no gaps.
- Enforces the mandatory flush gap between blocks.
- Reformats the encoder output stream into shortened/punctured codewords: K data bytes, then the first 2*t of the 16 parity bytes.
- Repeats for a configured number of blocks per burst.

Parameters:
- W, 8, byte width on all data paths
- PARITY, 16, parity bytes emitted by the encoder per block (2T)
- FLUSH_CYC, 18, idle encoder-input cycles required after the last data byte of a block
- LVL_W, 9, width of the upstream FIFO fill-level input

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cfg_start  in  1  one-cycle request to start a burst; latches cfg_k/cfg_t/cfg_nblk
- cfg_k  in  8  data bytes per block, legal 1..239
- cfg_t  in  4  kept parity pairs, legal 0..8; keeps 2*cfg_t parity bytes
- cfg_nblk  in  8  blocks in the burst, legal 1..255
- busy  out  1  high from accepted cfg_start until done
- done  out  1  one-cycle pulse when the last kept byte of the last block has been emitted
- cfg_err  out  1  one-cycle pulse when cfg_start carries illegal values
- fifo_level  in  LVL_W  bytes available in the upstream FIFO
- fifo_rd  out  1  FIFO read strobe; data is returned one cycle later
- fifo_data  in  W  FIFO read data
- enc_in_bits  out  W  byte to the encoder
- enc_in_valid  out  1  encoder input valid; must be contiguous within a block
- enc_out_bits  in  W  encoder output byte
- enc_out_valid  in  1  encoder output valid
- out_bits  out  W  shortened/punctured codeword byte
- out_valid  out  1  out_bits valid
- out_last  out  1  with out_valid, marks the final kept byte of each block

Behaviour:
- Reset (reset=0, asynchronous): all outputs are 0, both FSMs go to IDLE, all counters are 0. Reset taken mid-block abandons the burst; no done pulse follows.
- The input-side FSM has four states: IDLE, WAIT, DATA, FLUSH.
- IDLE:
  - cfg_start with legal config: latch config, set busy, go to WAIT.
  - cfg_start with illegal config (k=0, k>239, t>8, nblk=0): cfg_err pulses for one cycle; stay in IDLE with busy=0.
  - cfg_start while busy=1 is ignored.
- WAIT: wait until fifo_level >= k, then go to DATA. A block is never started on a partial fill, so the encoder input has no gaps.
- DATA: fifo_rd=1 for exactly k consecutive cycles, counted by a down-counter; then go to FLUSH.
- Encoder input path:
  - enc_in_valid is fifo_rd delayed by one register.
  - enc_in_bits = fifo_data, registered on the same cycle as enc_in_valid; it is 0 when not valid.
- FLUSH: fifo_rd=0 and enc_in_valid=0 for FLUSH_CYC cycles. Then go to WAIT if blocks remain, otherwise hold in IDLE with busy still 1 until the output side finishes.
- The output-side counter runs independently of the input FSM:
  - Counts enc_out_valid bytes per block, idx 0..k+PARITY-1, then wraps to 0 and increments the block count.
  - out_valid = enc_out_valid registered, and only if idx<k or (idx-k)<2*t. Dropped parity bytes produce out_valid=0.
  - out_bits is registered from enc_out_bits; it is 0 when out_valid=0.
  - Output latency is 1 cycle from enc_out_valid.
  - out_last is asserted on the byte with idx = k+2*t-1, which is idx k-1 when t=0.
- done pulses in the cycle after the last kept byte of block nblk is emitted; busy falls in the same cycle. A cfg_start in that cycle is not accepted.
- enc_out_valid arriving while not busy is ignored and produces no output.
- Width rules:
  - k+PARITY is computed in 9 bits, maximum 255.
  - The block counter is 8 bits and compared against the latched cfg_nblk.

Test Plan:
- k=239, t=8, nblk=1, fifo_level=300 -> fifo_rd high exactly 239 cycles; 255 out_valid bytes (239 data then 16 parity); out_last on byte 255; done once; busy then 0.
- k=20, t=4, nblk=2 -> 28 kept bytes per block; out_last on bytes 28 and 56; enc_in_valid low >=18 cycles between blocks; single done after byte 56.
- k=20, fifo_level held at 10, then raised to 20 -> fifo_rd stays 0 while level=10; 20-cycle read burst starts the cycle after level reaches 20.
- k=10, t=0, nblk=1 -> 10 output bytes equal to the input bytes; all 16 parity dropped; out_last on byte 10.
- cfg_start with k=240 -> cfg_err pulses one cycle; busy=0; fifo_rd never asserts. Then cfg_start with k=0, and with t=9 -> same response.
- reset driven 0 mid-DATA -> all outputs 0 immediately; no done pulse; new legal cfg_start after reset=1 runs a clean block.

Source files
------------

// File: rtl/rs_block_ctrl_if.sv
// Handshake bundle for rs_block_ctrl: configuration, upstream FIFO, encoder
// input/output and the shortened/punctured codeword stream.
interface rs_block_ctrl_if #(
    parameter int W     = 8,
    parameter int LVL_W = 9
);
    logic             cfg_start;
    logic [7:0]       cfg_k;
    logic [3:0]       cfg_t;
    logic [7:0]       cfg_nblk;
    logic             busy;
    logic             done;
    logic             cfg_err;
    logic [LVL_W-1:0] fifo_level;
    logic             fifo_rd;
    logic [W-1:0]     fifo_data;
    logic [W-1:0]     enc_in_bits;
    logic             enc_in_valid;
    logic [W-1:0]     enc_out_bits;
    logic             enc_out_valid;
    logic [W-1:0]     out_bits;
    logic             out_valid;
    logic             out_last;

    modport master (
        output cfg_start, cfg_k, cfg_t, cfg_nblk, fifo_level, fifo_data,
               enc_out_bits, enc_out_valid,
        input  busy, done, cfg_err, fifo_rd, enc_in_bits, enc_in_valid,
               out_bits, out_valid, out_last
    );

    modport slave (
        input  cfg_start, cfg_k, cfg_t, cfg_nblk, fifo_level, fifo_data,
               enc_out_bits, enc_out_valid,
        output busy, done, cfg_err, fifo_rd, enc_in_bits, enc_in_valid,
               out_bits, out_valid, out_last
    );
endinterface

// File: rtl/rs_block_ctrl.sv
// Block sequencer around an RS(255,239) byte encoder: feeds K-byte blocks with
// a flush gap, then shortens/punctures the encoder output to K + 2*t bytes.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | no block in flight; accepts cfg_start when busy=0
// S_WAIT  | waiting for the upstream FIFO to hold a full block (level >= k)
// S_DATA  | fifo_rd asserted for k consecutive cycles
// S_FLUSH | encoder input held idle for FLUSH_CYC cycles after the block
module rs_block_ctrl #(
    parameter int W         = 8,
    parameter int PARITY    = 16,
    parameter int FLUSH_CYC = 18,
    parameter int LVL_W     = 9
) (
    input logic           clk,
    input logic           reset,
    rs_block_ctrl_if.slave bus
);
    localparam int FL_W = $clog2(FLUSH_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA, S_FLUSH} in_state_t;

    in_state_t   state_q, state_d;
    logic [7:0]  k_q, k_d;
    logic [3:0]  t_q, t_d;
    logic [7:0]  nblk_q, nblk_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        cfg_err_q, cfg_err_d;
    logic        fifo_rd_q, fifo_rd_d;
    logic [7:0]  rd_cnt_q, rd_cnt_d;
    logic [FL_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [7:0]  blk_left_q, blk_left_d;
    logic        enc_in_valid_q, enc_in_valid_d;
    logic [W-1:0] enc_in_bits_q, enc_in_bits_d;
    logic [8:0]  out_idx_q, out_idx_d;
    logic [7:0]  out_blk_q, out_blk_d;
    logic        out_valid_q, out_valid_d;
    logic [W-1:0] out_bits_q, out_bits_d;
    logic        out_last_q, out_last_d;
    logic        out_final_q, out_final_d;

    logic        cfg_ok;
    logic [8:0]  kt_end;
    logic [8:0]  blk_end;
    logic        keep;
    logic        is_last_kept;

    assign cfg_ok  = (bus.cfg_k != 8'd0) && (bus.cfg_k <= 8'd239) &&
                     (bus.cfg_t <= 4'd8) && (bus.cfg_nblk != 8'd0);
    assign kt_end  = {1'b0, k_q} + {4'b0000, t_q, 1'b0};
    assign blk_end = {1'b0, k_q} + 9'(PARITY - 1);
    assign keep         = out_idx_q < kt_end;
    assign is_last_kept = out_idx_q == (kt_end - 9'd1);

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        t_d            = t_q;
        nblk_d         = nblk_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        cfg_err_d      = 1'b0;
        fifo_rd_d      = fifo_rd_q;
        rd_cnt_d       = rd_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        blk_left_d     = blk_left_q;
        out_idx_d      = out_idx_q;
        out_blk_d      = out_blk_q;
        out_valid_d    = 1'b0;
        out_bits_d     = '0;
        out_last_d     = 1'b0;
        out_final_d    = 1'b0;

        // FIFO returns data on the cycle after the strobe, so the strobe
        // delayed by one register lines up with the byte it fetched.
        enc_in_valid_d = fifo_rd_q;
        enc_in_bits_d  = fifo_rd_q ? bus.fifo_data : '0;

        case (state_q)
            S_IDLE: begin
                if (bus.cfg_start && !busy_q && !done_q) begin
                    if (cfg_ok) begin
                        k_d        = bus.cfg_k;
                        t_d        = bus.cfg_t;
                        nblk_d     = bus.cfg_nblk;
                        blk_left_d = bus.cfg_nblk;
                        busy_d     = 1'b1;
                        out_idx_d  = '0;
                        out_blk_d  = '0;
                        state_d    = S_WAIT;
                    end else begin
                        cfg_err_d  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.fifo_level >= LVL_W'(k_q)) begin
                    fifo_rd_d = 1'b1;
                    rd_cnt_d  = k_q - 8'd1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (rd_cnt_q == 8'd0) begin
                    fifo_rd_d   = 1'b0;
                    flush_cnt_d = FL_W'(FLUSH_CYC - 1);
                    blk_left_d  = blk_left_q - 8'd1;
                    state_d     = S_FLUSH;
                end else begin
                    rd_cnt_d    = rd_cnt_q - 8'd1;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = (blk_left_q != 8'd0) ? S_WAIT : S_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - FL_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (busy_q && bus.enc_out_valid) begin
            out_valid_d = keep;
            out_bits_d  = keep ? bus.enc_out_bits : '0;
            out_last_d  = is_last_kept;
            out_final_d = is_last_kept && (out_blk_q == nblk_q - 8'd1);
            if (out_idx_q == blk_end) begin
                out_idx_d = '0;
                out_blk_d = out_blk_q + 8'd1;
            end else begin
                out_idx_d = out_idx_q + 9'd1;
            end
        end

        // Trailing dropped parity of the final block arrives after busy falls
        // and is discarded by the busy gate above.
        if (out_final_q) begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            out_idx_d = '0;
            out_blk_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            t_q            <= '0;
            nblk_q         <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
            fifo_rd_q      <= 1'b0;
            rd_cnt_q       <= '0;
            flush_cnt_q    <= '0;
            blk_left_q     <= '0;
            enc_in_valid_q <= 1'b0;
            enc_in_bits_q  <= '0;
            out_idx_q      <= '0;
            out_blk_q      <= '0;
            out_valid_q    <= 1'b0;
            out_bits_q     <= '0;
            out_last_q     <= 1'b0;
            out_final_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            t_q            <= t_d;
            nblk_q         <= nblk_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
            fifo_rd_q      <= fifo_rd_d;
            rd_cnt_q       <= rd_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            blk_left_q     <= blk_left_d;
            enc_in_valid_q <= enc_in_valid_d;
            enc_in_bits_q  <= enc_in_bits_d;
            out_idx_q      <= out_idx_d;
            out_blk_q      <= out_blk_d;
            out_valid_q    <= out_valid_d;
            out_bits_q     <= out_bits_d;
            out_last_q     <= out_last_d;
            out_final_q    <= out_final_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.fifo_rd      = fifo_rd_q;
    assign bus.enc_in_bits  = enc_in_bits_q;
    assign bus.enc_in_valid = enc_in_valid_q;
    assign bus.out_bits     = out_bits_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
endmodule
